// File: rtl/hex_arb_pkg.sv
// Shared types and constants for the HEX display arbiter.
package hex_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [1:0] PIO_ADDR   = 2'd0;
    localparam int unsigned PIO_DATA_W = 16;
    localparam int unsigned AV_DATA_W  = 32;

endpackage

// File: rtl/hex_arb_timer.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module hex_arb_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/hex_display_arbiter.sv
// Arbitrates host and level-meter updates onto the HEX display PIO, with a
// post-write gap and a retriggerable host-hold window that locks out the meter.
module hex_display_arbiter
    import hex_arb_pkg::*;
#(
    parameter int unsigned MIN_GAP   = 50000,
    parameter int unsigned HOST_HOLD = 50000000,
    parameter int unsigned CNT_W     = 26
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    input  logic [PIO_DATA_W-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [PIO_DATA_W-1:0] req1_data,
    output logic                  req1_ready,
    output logic [1:0]            pio_address,
    output logic                  pio_chipselect,
    output logic                  pio_write_n,
    output logic [AV_DATA_W-1:0]  pio_writedata,
    output logic                  host_hold,
    output logic                  busy
);

    state_t                state_q, state_d;
    logic [PIO_DATA_W-1:0] data_q, data_d;
    logic                  cs_q, write_n_q;
    logic                  gap_load, hold_load;
    logic [CNT_W-1:0]      gap_cnt, hold_cnt;
    logic                  gap_zero, hold_zero;

    hex_arb_timer #(
        .CNT_W (CNT_W)
    ) u_gap_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (gap_load),
        .load_value (CNT_W'(MIN_GAP)),
        .count      (gap_cnt),
        .zero       (gap_zero)
    );

    hex_arb_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (hold_load),
        .load_value (CNT_W'(HOST_HOLD)),
        .count      (hold_cnt),
        .zero       (hold_zero)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        gap_load   = 1'b0;
        hold_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req0_ready = 1'b1;
                req1_ready = !req0_valid && hold_zero;
                if (req0_valid) begin
                    data_d    = req0_data;
                    hold_load = 1'b1;
                    state_d   = WRITE;
                end else if (req1_valid && req1_ready) begin
                    data_d  = req1_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (MIN_GAP == 0) begin
                    state_d = IDLE;
                end else begin
                    gap_load = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                // Leaving on count==1 makes the gap exactly MIN_GAP cycles long
                if (gap_cnt == CNT_W'(1) || gap_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cs_q      <= (state_d == WRITE);
            write_n_q <= (state_d != WRITE);
        end
    end

    assign pio_address    = PIO_ADDR;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = write_n_q;
    assign pio_writedata  = {{(AV_DATA_W - PIO_DATA_W){1'b0}}, data_q};
    assign host_hold      = (hold_cnt != '0);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench: main DUT with MIN_GAP=4/HOST_HOLD=20, second DUT with MIN_GAP=0.
module tb_hex_display_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        r0v, r1v;
    logic [15:0] r0d, r1d;
    logic        req0_ready, req1_ready;
    logic [1:0]  pio_address;
    logic        pio_cs, pio_wn;
    logic [31:0] pio_wd;
    logic        host_hold, busy;

    logic        b_r0v, b_r1v;
    logic [15:0] b_r0d, b_r1d;
    logic        b_req0_ready, b_req1_ready;
    logic [1:0]  b_pio_address;
    logic        b_pio_cs, b_pio_wn;
    logic [31:0] b_pio_wd;
    logic        b_host_hold, b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hex_display_arbiter #(
        .MIN_GAP   (4),
        .HOST_HOLD (20),
        .CNT_W     (26)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0_valid     (r0v),
        .req0_data      (r0d),
        .req0_ready     (req0_ready),
        .req1_valid     (r1v),
        .req1_data      (r1d),
        .req1_ready     (req1_ready),
        .pio_address    (pio_address),
        .pio_chipselect (pio_cs),
        .pio_write_n    (pio_wn),
        .pio_writedata  (pio_wd),
        .host_hold      (host_hold),
        .busy           (busy)
    );

    hex_display_arbiter #(
        .MIN_GAP   (0),
        .HOST_HOLD (0),
        .CNT_W     (26)
    ) dut_nogap (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0_valid     (b_r0v),
        .req0_data      (b_r0d),
        .req0_ready     (b_req0_ready),
        .req1_valid     (b_r1v),
        .req1_data      (b_r1d),
        .req1_ready     (b_req1_ready),
        .pio_address    (b_pio_address),
        .pio_chipselect (b_pio_cs),
        .pio_write_n    (b_pio_wn),
        .pio_writedata  (b_pio_wd),
        .host_hold      (b_host_hold),
        .busy           (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Each cycle window opens 2 time units after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Counts cycles until busy drops, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            #1;
            n++;
            if (!busy) break;
        end
        check("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        r0v = 0; r1v = 0; r0d = '0; r1d = '0;
        b_r0v = 0; b_r1v = 0; b_r0d = '0; b_r1d = '0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // 1: idle after reset
        #1;
        check("rst_addr", {30'b0, pio_address}, 32'd0);
        check("rst_wd", pio_wd, 32'd0);
        for (int c = 0; c < 50; c++) begin
            next_cycle();
            #1;
            check("t1_wn", {31'b0, pio_wn}, 32'd1);
            check("t1_cs", {31'b0, pio_cs}, 32'd0);
            check("t1_busy", {31'b0, busy}, 32'd0);
            check("t1_hold", {31'b0, host_hold}, 32'd0);
        end

        // 2: meter write 0x1234
        next_cycle();
        r1v = 1; r1d = 16'h1234;
        #1;
        check("t2_r1rdy_c0", {31'b0, req1_ready}, 32'd1);
        next_cycle();
        r1v = 0;
        #1;
        check("t2_cs_c1", {31'b0, pio_cs}, 32'd1);
        check("t2_wn_c1", {31'b0, pio_wn}, 32'd0);
        check("t2_wd_c1", pio_wd, 32'h0000_1234);
        check("t2_busy_c1", {31'b0, busy}, 32'd1);
        check("t2_r0rdy_c1", {31'b0, req0_ready}, 32'd0);
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            #1;
            check("t2_gap_cs", {31'b0, pio_cs}, 32'd0);
            check("t2_gap_busy", {31'b0, busy}, 32'd1);
            check("t2_gap_r1rdy", {31'b0, req1_ready}, 32'd0);
        end
        next_cycle();
        #1;
        check("t2_busy_c6", {31'b0, busy}, 32'd0);
        check("t2_r1rdy_c6", {31'b0, req1_ready}, 32'd1);

        // 3: simultaneous requests, host wins, meter locked out by hold
        next_cycle();
        r0v = 1; r0d = 16'hBEEF; r1v = 1; r1d = 16'h0001;
        #1;
        check("t3_r0rdy_c0", {31'b0, req0_ready}, 32'd1);
        check("t3_r1rdy_c0", {31'b0, req1_ready}, 32'd0);
        next_cycle();
        r0v = 0;
        #1;
        check("t3_cs_c1", {31'b0, pio_cs}, 32'd1);
        check("t3_wd_c1", pio_wd, 32'h0000_BEEF);
        check("t3_hold_c1", {31'b0, host_hold}, 32'd1);
        for (int c = 2; c <= 20; c++) begin
            next_cycle();
            #1;
            check("t3_r1rdy_locked", {31'b0, req1_ready}, 32'd0);
            check("t3_hold_on", {31'b0, host_hold}, 32'd1);
            check("t3_cs_quiet", {31'b0, pio_cs}, 32'd0);
        end
        next_cycle();
        #1;
        check("t3_hold_c21", {31'b0, host_hold}, 32'd0);
        check("t3_r1rdy_c21", {31'b0, req1_ready}, 32'd1);
        next_cycle();
        r1v = 0;
        #1;
        check("t3_cs_c22", {31'b0, pio_cs}, 32'd1);
        check("t3_wd_c22", pio_wd, 32'h0000_0001);
        wait_idle(n);
        check("t3_gap_len", n, 32'd5);

        // 4: retriggered hold
        next_cycle();
        r0v = 1; r0d = 16'hA5A5; r1v = 1; r1d = 16'h7777;
        #1;
        check("t4_r1rdy_c0", {31'b0, req1_ready}, 32'd0);
        for (int c = 1; c <= 30; c++) begin
            next_cycle();
            if (c == 1 || c == 11) r0v = 0;
            if (c == 10) begin
                r0v = 1; r0d = 16'h5A5A;
            end
            #1;
            check("t4_r1rdy_locked", {31'b0, req1_ready}, 32'd0);
            check("t4_cs", {31'b0, pio_cs}, (c == 1 || c == 11) ? 32'd1 : 32'd0);
            if (c == 1) check("t4_wd_c1", pio_wd, 32'h0000_A5A5);
            if (c == 11) check("t4_wd_c11", pio_wd, 32'h0000_5A5A);
            if (c == 10) check("t4_r0rdy_c10", {31'b0, req0_ready}, 32'd1);
        end
        next_cycle();
        #1;
        check("t4_r1rdy_c31", {31'b0, req1_ready}, 32'd1);
        check("t4_hold_c31", {31'b0, host_hold}, 32'd0);
        next_cycle();
        r1v = 0;
        #1;
        check("t4_cs_c32", {31'b0, pio_cs}, 32'd1);
        check("t4_wd_c32", pio_wd, 32'h0000_7777);
        wait_idle(n);

        // 5: reset on the accepting edge aborts the write and clears the hold
        next_cycle();
        r0v = 1; r0d = 16'h1111;
        #1;
        next_cycle();
        r0v = 0;
        #1;
        check("t5_wd_pre", pio_wd, 32'h0000_1111);
        wait_idle(n);
        check("t5_hold_pre", {31'b0, host_hold}, 32'd1);
        r0v = 1; r0d = 16'hCAFE;
        #1;
        reset_n = 1'b0;
        next_cycle();
        #1;
        check("t5_cs_rst", {31'b0, pio_cs}, 32'd0);
        check("t5_wn_rst", {31'b0, pio_wn}, 32'd1);
        check("t5_busy_rst", {31'b0, busy}, 32'd0);
        check("t5_hold_rst", {31'b0, host_hold}, 32'd0);
        check("t5_wd_rst", pio_wd, 32'd0);
        r0v = 0;
        reset_n = 1'b1;
        #1;
        check("t5_r0rdy_rel", {31'b0, req0_ready}, 32'd1);
        check("t5_r1rdy_rel", {31'b0, req1_ready}, 32'd1);
        next_cycle();
        #1;
        check("t5_cs_after", {31'b0, pio_cs}, 32'd0);
        check("t5_busy_after", {31'b0, busy}, 32'd0);

        // 6: no-gap build, one write every two cycles, data advances per accept
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            b_r1v = 1;
            b_r1d = 16'h0100 + 16'(c / 2);
            #1;
            check("t6_r1rdy", {31'b0, b_req1_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check("t6_cs", {31'b0, b_pio_cs}, (c % 2 == 1) ? 32'd1 : 32'd0);
            if (c % 2 == 1) begin
                check("t6_wd", b_pio_wd, 32'h0000_0100 + 32'(c / 2));
            end
            check("t6_hold", {31'b0, b_host_hold}, 32'd0);
        end
        b_r1v = 0;
        next_cycle();
        next_cycle();
        #1;
        check("t6_quiet", {31'b0, b_pio_cs}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
